// File: rtl/prefix_seq_pkg.sv
// Shared types and sizing helpers for the chunk-serial prefix AND-OR engine.
package prefix_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} prefix_seq_state_t;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/prefix_chunk.sv
// One chunk of the prefix: local group generate/propagate in the chosen topology,
// then merged with the running carry and propagate from the lower chunks.
module prefix_chunk
    import prefix_seq_pkg::*;
#(
    parameter int chunk = 8,
    parameter int speed = 1
) (
    input  logic [chunk-1:0] gen,
    input  logic [chunk-1:0] prop,
    input  logic             carry,
    input  logic             grp_prop,
    output logic [chunk-1:0] go,
    output logic [chunk-1:0] po,
    output logic             carry_next,
    output logic             prop_next
);

    localparam int LG = $clog2(chunk);

    logic [chunk-1:0] gl;
    logic [chunk-1:0] pl;

    // In every topology node j is never rewritten in the level that reads it,
    // so the in-place update is safe.
    always_comb begin
        gl = gen;
        pl = prop;
        if (speed == 0) begin
            for (int i = 1; i < chunk; i++) begin
                gl[i] = gl[i] | (pl[i] & gl[i-1]);
                pl[i] = pl[i] & pl[i-1];
            end
        end else if (speed == 1) begin
            for (int l = 0; l < LG; l++)
                for (int i = 0; i < chunk; i++)
                    if ((i % (2 << l)) == ((2 << l) - 1)) begin
                        gl[i] = gl[i] | (pl[i] & gl[i-(1<<l)]);
                        pl[i] = pl[i] & pl[i-(1<<l)];
                    end
            for (int l = LG - 2; l >= 0; l--)
                for (int i = 0; i < chunk; i++)
                    if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (1 << l))) begin
                        gl[i] = gl[i] | (pl[i] & gl[i-(1<<l)]);
                        pl[i] = pl[i] & pl[i-(1<<l)];
                    end
        end else begin
            for (int l = 0; l < LG; l++)
                for (int i = 0; i < chunk; i++)
                    if (((i >> l) & 1) == 1) begin
                        gl[i] = gl[i] | (pl[i] & gl[((i >> l) << l) - 1]);
                        pl[i] = pl[i] & pl[((i >> l) << l) - 1];
                    end
        end
    end

    assign go         = gl | (pl & {chunk{carry}});
    assign po         = pl & {chunk{grp_prop}};
    assign carry_next = go[chunk-1];
    assign prop_next  = po[chunk-1];

endmodule

// File: rtl/prefix_and_or_seq.sv
// Chunk-serial prefix AND-OR engine: one chunk per cycle, carry/propagate
// held in registers between chunks, valid/ready on both sides.
module prefix_and_or_seq
    import prefix_seq_pkg::*;
#(
    parameter int width = 32,
    parameter int chunk = 8,
    parameter int speed = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] GI,
    input  logic [width-1:0] PI,
    input  logic             CI,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] GO,
    output logic [width-1:0] PO
);

    localparam int N  = num_chunks(width, chunk);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if ((chunk < 2) || ((chunk & (chunk - 1)) != 0) || ((width % chunk) != 0)
        || (speed < 0) || (speed > 2)) begin : g_bad_params
        $error("prefix_and_or_seq: illegal width/chunk/speed combination");
    end

    prefix_seq_state_t state;
    logic [IW-1:0]     idx;
    logic              c;
    logic              p;
    logic [width-1:0]  gi_r;
    logic [width-1:0]  pi_r;

    logic [chunk-1:0]  s_go;
    logic [chunk-1:0]  s_po;
    logic              s_c;
    logic              s_p;

    prefix_chunk #(
        .chunk (chunk),
        .speed (speed)
    ) u_chunk (
        .gen        (gi_r[idx*chunk +: chunk]),
        .prop       (pi_r[idx*chunk +: chunk]),
        .carry      (c),
        .grp_prop   (p),
        .go         (s_go),
        .po         (s_po),
        .carry_next (s_c),
        .prop_next  (s_p)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            GO        <= '0;
            PO        <= '0;
            gi_r      <= '0;
            pi_r      <= '0;
            c         <= 1'b0;
            p         <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        gi_r     <= GI;
                        pi_r     <= PI;
                        c        <= CI;
                        p        <= 1'b1;
                        idx      <= '0;
                        GO       <= '0;
                        PO       <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    GO[idx*chunk +: chunk] <= s_go;
                    PO[idx*chunk +: chunk] <= s_po;
                    c <= s_c;
                    p <= s_p;
                    // Exit is decided on the last chunk so idx never wraps.
                    if (idx == IW'(N - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prefix_and_or_seq.sv
// Scoreboard bench for prefix_and_or_seq over (32,8) and (16,16) at all speeds.
module tb_prefix_and_or_seq;

    localparam int ND = 6;

    typedef struct {
        logic [31:0] go;
        logic [31:0] po;
        int          hs;
    } exp_t;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [ND-1:0] rst, iv, ir, ov, ordy, ci;
    logic [ND-1:0] rnd = '0;
    logic [ND-1:0] fixed;
    logic          rmode;
    logic [31:0]   gi [ND];
    logic [31:0]   pi [ND];
    logic [31:0]   go [ND];
    logic [31:0]   po [ND];
    exp_t          sbq [ND][$];

    assign ordy = rmode ? rnd : fixed;
    always @(posedge CLK) rnd <= ND'($urandom);

    for (genvar k = 0; k < ND; k++) begin : g_dut
        localparam int W = (k < 3) ? 32 : 16;
        localparam int C = (k < 3) ? 8 : 16;
        logic [W-1:0] go_w, po_w;
        prefix_and_or_seq #(.width(W), .chunk(C), .speed(k % 3)) u_dut (
            .CLK       (CLK),
            .RST       (rst[k]),
            .in_valid  (iv[k]),
            .in_ready  (ir[k]),
            .GI        (gi[k][W-1:0]),
            .PI        (pi[k][W-1:0]),
            .CI        (ci[k]),
            .out_valid (ov[k]),
            .out_ready (ordy[k]),
            .GO        (go_w),
            .PO        (po_w)
        );
        assign go[k] = 32'(go_w);
        assign po[k] = 32'(po_w);
    end

    function automatic int nch(input int k);
        return (k < 3) ? 4 : 1;
    endfunction

    function automatic int wid(input int k);
        return (k < 3) ? 32 : 16;
    endfunction

    function automatic logic [31:0] msk(input int k);
        return (k < 3) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    endfunction

    // Bit-serial definition: carry into bit i+1 is G[i] | P[i]&carry_i.
    task automatic ref_model(input logic [31:0] g, input logic [31:0] p, input logic c,
                             input int w, output logic [31:0] ego, output logic [31:0] epo);
        logic cy, pr;
        cy  = c;
        pr  = 1'b1;
        ego = '0;
        epo = '0;
        for (int i = 0; i < w; i++) begin
            cy     = g[i] | (p[i] & cy);
            pr     = pr & p[i];
            ego[i] = cy;
            epo[i] = pr;
        end
    endtask

    task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task step;
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input int k, input logic [31:0] g, input logic [31:0] p, input logic c,
                         input logic [31:0] ego, input logic [31:0] epo);
        exp_t e;
        int   n;
        n     = 0;
        gi[k] = g & msk(k);
        pi[k] = p & msk(k);
        ci[k] = c;
        iv[k] = 1'b1;
        while (!ir[k] && n < 100) begin
            step;
            n++;
        end
        if (!ir[k]) begin
            check("issue_timeout", k, 32'(ir[k]), 32'd1);
        end else begin
            e.go = ego & msk(k);
            e.po = epo & msk(k);
            e.hs = cyc + 1;
            sbq[k].push_back(e);
            step;
        end
        iv[k] = 1'b0;
    endtask

    task automatic issue_rand(input int k);
        logic [31:0] g, p, ego, epo;
        logic        c;
        g = $urandom;
        p = $urandom;
        if ($urandom_range(0, 3) == 0) p = p | 32'hFFFF_FF00;
        c = 1'($urandom_range(0, 1));
        ref_model(g & msk(k), p & msk(k), c, wid(k), ego, epo);
        issue(k, g, p, c, ego, epo);
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (sbq[k].size() != 0 && n < 300) begin
            step;
            n++;
        end
        if (sbq[k].size() != 0) begin
            check("drain_timeout", k, 32'(sbq[k].size()), 32'd0);
            sbq[k].delete();
        end
        step;
    endtask

    logic [ND-1:0] prev_ov = '0;
    always @(negedge CLK) begin
        exp_t e;
        for (int k = 0; k < ND; k++) begin
            if (ov[k] && !prev_ov[k] && sbq[k].size() > 0)
                check("latency", k, 32'(cyc - sbq[k][0].hs), 32'(nch(k)));
            if (ov[k] && ordy[k]) begin
                if (sbq[k].size() == 0) begin
                    check("unexpected_output", k, go[k], 32'hxxxx_xxxx);
                end else begin
                    e = sbq[k].pop_front();
                    check("GO", k, go[k], e.go);
                    check("PO", k, po[k], e.po);
                end
            end
            prev_ov[k] = ov[k];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rmode = 1'b0;
        fixed = '1;
        iv    = '0;
        ci    = '0;
        rst   = '1;
        for (int k = 0; k < ND; k++) begin
            gi[k] = '0;
            pi[k] = '0;
        end
        step;
        step;
        for (int k = 0; k < ND; k++) begin
            check("rst_out_valid", k, 32'(ov[k]), 32'd0);
            check("rst_in_ready", k, 32'(ir[k]), 32'd1);
            check("rst_GO", k, go[k], 32'd0);
            check("rst_PO", k, po[k], 32'd0);
        end
        rst = '0;
        step;

        for (int k = 0; k < ND; k++) begin
            rmode = 1'b1;
            issue(k, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            issue(k, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
            issue(k, 32'h0000_0080, 32'h0000_FF00, 1'b0, 32'h0000_FF80, 32'h0000_0000);
            drain(k);

            // Back-pressure: result must sit in DONE untouched while in_valid is asserted.
            rmode    = 1'b0;
            fixed[k] = 1'b0;
            issue(k, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            n = 0;
            while (!ov[k] && n < 50) begin
                step;
                n++;
            end
            repeat (3) begin
                iv[k] = 1'b1;
                gi[k] = 32'h1234_5678 & msk(k);
                pi[k] = 32'h0F0F_0F0F & msk(k);
                check("bp_out_valid", k, 32'(ov[k]), 32'd1);
                check("bp_in_ready", k, 32'(ir[k]), 32'd0);
                check("bp_GO", k, go[k], msk(k));
                check("bp_PO", k, po[k], msk(k));
                step;
            end
            iv[k]    = 1'b0;
            fixed[k] = 1'b1;
            step;
            check("accept_out_valid", k, 32'(ov[k]), 32'd0);
            check("accept_in_ready", k, 32'(ir[k]), 32'd1);
            issue(k, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);
            drain(k);

            // Reset while RUN is at chunk 2 (or its only chunk when N=1).
            issue(k, 32'h0000_0080, 32'h0000_FF00, 1'b0, 32'h0000_FF80, 32'h0000_0000);
            repeat ((nch(k) > 2) ? 2 : nch(k) - 1) step;
            rst[k] = 1'b1;
            step;
            check("midrst_out_valid", k, 32'(ov[k]), 32'd0);
            check("midrst_GO", k, go[k], 32'd0);
            check("midrst_PO", k, po[k], 32'd0);
            check("midrst_in_ready", k, 32'(ir[k]), 32'd1);
            rst[k] = 1'b0;
            sbq[k].delete();
            step;
            issue(k, 32'h0000_0080, 32'h0000_FF00, 1'b0, 32'h0000_FF80, 32'h0000_0000);
            drain(k);

            rmode = 1'b1;
            repeat (170) issue_rand(k);
            drain(k);
            rmode = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
